// File: rtl/sc_randgen_arbiter_if.sv
// Handshake bundle for the LFSR random-number arbiter: seed load, draw
// requests/acks, drawn value and busy flag.
interface sc_randgen_arbiter_if;
   logic [7:0] SC_RANDGEN_ARBITER_seed_InBUS;
   logic       SC_RANDGEN_ARBITER_seedvalid_In;
   logic [1:0] SC_RANDGEN_ARBITER_req_InBUS;
   logic [1:0] SC_RANDGEN_ARBITER_ack_OutBUS;
   logic [7:0] SC_RANDGEN_ARBITER_data_OutBUS;
   logic       SC_RANDGEN_ARBITER_busy_Out;

   modport master (
      output SC_RANDGEN_ARBITER_seed_InBUS,
      output SC_RANDGEN_ARBITER_seedvalid_In,
      output SC_RANDGEN_ARBITER_req_InBUS,
      input  SC_RANDGEN_ARBITER_ack_OutBUS,
      input  SC_RANDGEN_ARBITER_data_OutBUS,
      input  SC_RANDGEN_ARBITER_busy_Out
   );

   modport slave (
      input  SC_RANDGEN_ARBITER_seed_InBUS,
      input  SC_RANDGEN_ARBITER_seedvalid_In,
      input  SC_RANDGEN_ARBITER_req_InBUS,
      output SC_RANDGEN_ARBITER_ack_OutBUS,
      output SC_RANDGEN_ARBITER_data_OutBUS,
      output SC_RANDGEN_ARBITER_busy_Out
   );
endinterface

// File: rtl/sc_randgen_arbiter.sv
// Two-requester round-robin arbiter handing out draws from an 8-bit
// Fibonacci LFSR that advances RANDGEN_STEPS times per draw.
module sc_randgen_arbiter #(
   parameter int RANDGEN_STEPS = 8
) (
   input logic                 SC_RANDGEN_ARBITER_CLOCK_50,
   input logic                 SC_RANDGEN_ARBITER_RESET_InLow,
   sc_randgen_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] STEP = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [7:0] ZERO_SEED_SUBSTITUTE = 8'h43;

   logic [1:0] state;
   logic [7:0] lfsr;
   logic [7:0] seedHold;
   logic [7:0] dataReg;
   logic [3:0] stepCount;
   logic [1:0] ackReg;
   logic       grant;
   logic       lastGrant;
   logic       pickGrant;
   logic [7:0] lfsrStepped;

   assign lfsrStepped = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   // Round-robin choice: contention goes to whoever was not served last,
   // a lone requester always wins.
   always_comb begin
      pickGrant = 1'b0;
      if (bus.SC_RANDGEN_ARBITER_req_InBUS == 2'b11)
         pickGrant = ~lastGrant;
      else if (bus.SC_RANDGEN_ARBITER_req_InBUS[1])
         pickGrant = 1'b1;
   end

   always_ff @(posedge SC_RANDGEN_ARBITER_CLOCK_50 or negedge SC_RANDGEN_ARBITER_RESET_InLow) begin
      if (!SC_RANDGEN_ARBITER_RESET_InLow) begin
         state     <= IDLE;
         lfsr      <= ZERO_SEED_SUBSTITUTE;
         seedHold  <= 8'h00;
         dataReg   <= 8'h00;
         stepCount <= 4'd0;
         ackReg    <= 2'b00;
         grant     <= 1'b0;
         lastGrant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.SC_RANDGEN_ARBITER_seedvalid_In) begin
                  seedHold <= bus.SC_RANDGEN_ARBITER_seed_InBUS;
                  state    <= LOAD;
               end else if (|bus.SC_RANDGEN_ARBITER_req_InBUS) begin
                  grant     <= pickGrant;
                  stepCount <= 4'(RANDGEN_STEPS - 1);
                  state     <= STEP;
               end
            end
            LOAD: begin
               // An all-zero LFSR would lock up, so zero is swapped for the reset value.
               lfsr  <= (seedHold == 8'h00) ? ZERO_SEED_SUBSTITUTE : seedHold;
               state <= IDLE;
            end
            STEP: begin
               lfsr <= lfsrStepped;
               if (stepCount == 4'd0) begin
                  dataReg <= lfsrStepped;
                  ackReg  <= grant ? 2'b10 : 2'b01;
                  state   <= DONE;
               end else begin
                  stepCount <= stepCount - 4'd1;
               end
            end
            DONE: begin
               ackReg    <= 2'b00;
               lastGrant <= grant;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.SC_RANDGEN_ARBITER_ack_OutBUS  = ackReg;
   assign bus.SC_RANDGEN_ARBITER_data_OutBUS = dataReg;
   assign bus.SC_RANDGEN_ARBITER_busy_Out    = (state != IDLE);

endmodule

// File: tb/tb_sc_randgen_arbiter.sv
// Directed bench for sc_randgen_arbiter: one instance with 8 steps per draw,
// one with a single step, expected draws queued in a scoreboard.
module tb_sc_randgen_arbiter;

   typedef struct {
      logic [1:0] ack;
      logic [7:0] data;
   } expect_t;

   logic clock = 1'b0;
   logic resetN = 1'b0;

   int checks = 0;
   int failures = 0;

   expect_t scoreboard[$];
   logic [7:0] model8;
   logic [7:0] model1;

   sc_randgen_arbiter_if bus8();
   sc_randgen_arbiter_if bus1();

   sc_randgen_arbiter #(.RANDGEN_STEPS(8)) dut8 (
      .SC_RANDGEN_ARBITER_CLOCK_50    (clock),
      .SC_RANDGEN_ARBITER_RESET_InLow (resetN),
      .bus                            (bus8)
   );

   sc_randgen_arbiter #(.RANDGEN_STEPS(1)) dut1 (
      .SC_RANDGEN_ARBITER_CLOCK_50    (clock),
      .SC_RANDGEN_ARBITER_RESET_InLow (resetN),
      .bus                            (bus1)
   );

   always #5 clock = ~clock;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0.
   function automatic logic [7:0] advance(input logic [7:0] r, input int n);
      logic [7:0] v;
      v = r;
      for (int i = 0; i < n; i++)
         v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int which, input logic [1:0] req);
      if (which == 8) bus8.SC_RANDGEN_ARBITER_req_InBUS = req;
      else            bus1.SC_RANDGEN_ARBITER_req_InBUS = req;
   endtask

   task automatic pulseSeed(input int which, input logic [7:0] seed);
      if (which == 8) begin
         bus8.SC_RANDGEN_ARBITER_seed_InBUS   = seed;
         bus8.SC_RANDGEN_ARBITER_seedvalid_In = 1'b1;
      end else begin
         bus1.SC_RANDGEN_ARBITER_seed_InBUS   = seed;
         bus1.SC_RANDGEN_ARBITER_seedvalid_In = 1'b1;
      end
   endtask

   task automatic dropSeed();
      bus8.SC_RANDGEN_ARBITER_seedvalid_In = 1'b0;
      bus1.SC_RANDGEN_ARBITER_seedvalid_In = 1'b0;
   endtask

   task automatic readBus(input int which, output logic [1:0] a, output logic [7:0] d, output logic b);
      if (which == 8) begin
         a = bus8.SC_RANDGEN_ARBITER_ack_OutBUS;
         d = bus8.SC_RANDGEN_ARBITER_data_OutBUS;
         b = bus8.SC_RANDGEN_ARBITER_busy_Out;
      end else begin
         a = bus1.SC_RANDGEN_ARBITER_ack_OutBUS;
         d = bus1.SC_RANDGEN_ARBITER_data_OutBUS;
         b = bus1.SC_RANDGEN_ARBITER_busy_Out;
      end
   endtask

   // Queue an expected draw, advancing the reference LFSR of that instance.
   task automatic expectDraw(input int which, input logic [1:0] ack);
      expect_t e;
      if (which == 8) begin
         model8 = advance(model8, 8);
         e.data = model8;
      end else begin
         model1 = advance(model1, 1);
         e.data = model1;
      end
      e.ack = ack;
      scoreboard.push_back(e);
   endtask

   // Wait (bounded) for an ack, then pop the scoreboard and compare.
   task automatic drawCheck(input int which, input string tag, input int latency);
      logic [1:0] a;
      logic [7:0] d;
      logic       b;
      int         cycles;
      expect_t    e;
      cycles = 0;
      a = 2'b00;
      d = 8'h00;
      b = 1'b0;
      while (cycles < 40) begin
         @(negedge clock);
         cycles++;
         readBus(which, a, d, b);
         if (a != 2'b00) break;
      end
      e = scoreboard.pop_front();
      checkOutput({tag, "_ack"}, 16'(a), 16'(e.ack));
      checkOutput({tag, "_data"}, 16'(d), 16'(e.data));
      checkOutput({tag, "_latency"}, 16'(cycles), 16'(latency));
      checkOutput({tag, "_busy"}, 16'(b), 16'(1'b1));
   endtask

   task automatic checkIdleAfter(input int which, input string tag, input logic [7:0] heldData);
      logic [1:0] a;
      logic [7:0] d;
      logic       b;
      @(negedge clock);
      readBus(which, a, d, b);
      checkOutput({tag, "_ackdrop"}, 16'(a), 16'(2'b00));
      checkOutput({tag, "_idlebusy"}, 16'(b), 16'(1'b0));
      checkOutput({tag, "_hold"}, 16'(d), 16'(heldData));
   endtask

   task automatic doReset();
      @(negedge clock);
      resetN = 1'b0;
      applyStimulus(8, 2'b00);
      applyStimulus(1, 2'b00);
      model8 = 8'h43;
      model1 = 8'h43;
      @(negedge clock);
      resetN = 1'b1;
   endtask

   initial begin
      logic [1:0] a;
      logic [7:0] d;
      logic       b;
      expect_t    e;

      bus8.SC_RANDGEN_ARBITER_seed_InBUS   = 8'h00;
      bus8.SC_RANDGEN_ARBITER_seedvalid_In = 1'b0;
      bus8.SC_RANDGEN_ARBITER_req_InBUS    = 2'b00;
      bus1.SC_RANDGEN_ARBITER_seed_InBUS   = 8'h00;
      bus1.SC_RANDGEN_ARBITER_seedvalid_In = 1'b0;
      bus1.SC_RANDGEN_ARBITER_req_InBUS    = 2'b00;
      model8 = 8'h43;
      model1 = 8'h43;

      // Reset values on both instances.
      @(negedge clock);
      readBus(8, a, d, b);
      checkOutput("rst8_ack", 16'(a), 16'(2'b00));
      checkOutput("rst8_data", 16'(d), 16'(8'h00));
      checkOutput("rst8_busy", 16'(b), 16'(1'b0));
      readBus(1, a, d, b);
      checkOutput("rst1_ack", 16'(a), 16'(2'b00));
      checkOutput("rst1_data", 16'(d), 16'(8'h00));
      checkOutput("rst1_busy", 16'(b), 16'(1'b0));
      @(negedge clock);
      resetN = 1'b1;

      // Eight-step draw from the reset LFSR value.
      $display("[TB] eight-step draw after reset");
      applyStimulus(8, 2'b01);
      e.ack = 2'b01;
      e.data = 8'h63;
      scoreboard.push_back(e);
      model8 = advance(model8, 8);
      drawCheck(8, "draw8", 9);
      applyStimulus(8, 2'b00);
      checkIdleAfter(8, "draw8", 8'h63);

      // Single-step draws back to back with the request held.
      $display("[TB] single-step back-to-back draws");
      applyStimulus(1, 2'b01);
      expectDraw(1, 2'b01);
      drawCheck(1, "step1_first", 2);
      expectDraw(1, 2'b01);
      drawCheck(1, "step1_second", 3);
      applyStimulus(1, 2'b00);
      checkIdleAfter(1, "step1", model1);

      // Both requesters held from reset: strict alternation.
      $display("[TB] round-robin contention");
      doReset();
      applyStimulus(8, 2'b11);
      expectDraw(8, 2'b01);
      drawCheck(8, "rr_0", 9);
      expectDraw(8, 2'b10);
      drawCheck(8, "rr_1", 10);
      expectDraw(8, 2'b01);
      drawCheck(8, "rr_2", 10);
      expectDraw(8, 2'b10);
      drawCheck(8, "rr_3", 10);
      applyStimulus(8, 2'b00);
      checkIdleAfter(8, "rr", model8);

      // Lone requester 1 wins even though it was served last.
      applyStimulus(8, 2'b10);
      expectDraw(8, 2'b10);
      drawCheck(8, "lone1", 9);
      applyStimulus(8, 2'b00);
      checkIdleAfter(8, "lone1", model8);

      // Zero seed replaced by 8'h43, then an explicit seed.
      $display("[TB] seed loading");
      @(negedge clock);
      pulseSeed(1, 8'h00);
      @(negedge clock);
      dropSeed();
      readBus(1, a, d, b);
      checkOutput("seed0_loadbusy", 16'(b), 16'(1'b1));
      @(negedge clock);
      model1 = 8'h43;
      applyStimulus(1, 2'b01);
      expectDraw(1, 2'b01);
      drawCheck(1, "seed0", 2);
      applyStimulus(1, 2'b00);
      @(negedge clock);
      pulseSeed(1, 8'h86);
      @(negedge clock);
      dropSeed();
      @(negedge clock);
      model1 = 8'h86;
      applyStimulus(1, 2'b01);
      expectDraw(1, 2'b01);
      drawCheck(1, "seed86", 2);
      applyStimulus(1, 2'b00);
      checkIdleAfter(1, "seed86", 8'h0D);

      // Seed pulse during a draw must be dropped.
      $display("[TB] seed pulse while busy");
      applyStimulus(8, 2'b01);
      expectDraw(8, 2'b01);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         readBus(8, a, d, b);
         checkOutput("seedbusy_busy", 16'(b), 16'(1'b1));
         if (i == 2) pulseSeed(8, 8'h55);
         if (i == 3) dropSeed();
      end
      drawCheck(8, "seedbusy", 5);
      applyStimulus(8, 2'b00);
      checkIdleAfter(8, "seedbusy", model8);
      applyStimulus(8, 2'b01);
      expectDraw(8, 2'b01);
      drawCheck(8, "seedbusy_next", 9);
      applyStimulus(8, 2'b00);
      checkIdleAfter(8, "seedbusy_next", model8);

      // Reset in the middle of a draw aborts it.
      $display("[TB] reset during draw");
      applyStimulus(8, 2'b01);
      repeat (4) @(negedge clock);
      resetN = 1'b0;
      #1;
      readBus(8, a, d, b);
      checkOutput("midrst_ack", 16'(a), 16'(2'b00));
      checkOutput("midrst_data", 16'(d), 16'(8'h00));
      checkOutput("midrst_busy", 16'(b), 16'(1'b0));
      @(negedge clock);
      resetN = 1'b1;
      model8 = advance(8'h43, 8);
      e.ack = 2'b01;
      e.data = 8'h63;
      scoreboard.push_back(e);
      drawCheck(8, "midrst_redraw", 9);
      applyStimulus(8, 2'b00);
      checkIdleAfter(8, "midrst", 8'h63);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Never both acks at once, on either instance.
   always @(negedge clock) begin
      if (resetN) begin
         if (bus8.SC_RANDGEN_ARBITER_ack_OutBUS == 2'b11 || bus1.SC_RANDGEN_ARBITER_ack_OutBUS == 2'b11)
            checkOutput("ack_onehot", 16'(2'b11), 16'(2'b00));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
